// File: rtl/apuf_eval_ctrl.sv
// Purpose : sequences one arbiter-PUF delay line (precharge / launch / sample, repeated) and majority-votes the result.
// Latency : resp_valid rises repeats*(2*settle_cycles+1)+1 cycles after the accepting edge.
// Backpressure: one request in flight; req_ready stays low until the response handshake, and the response is held while resp_ready is low.
//
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   req_valid/req_ready        challenge request handshake, req_challenge sampled on accept
//   challenge_out, launch      drive the delay line (launch feeds its clk input)
//   arb_in                     arbiter flop output, asynchronous to clk
//   resp_valid/resp_ready      response handshake carrying resp_bit and resp_ones
//   busy                       high in any state other than IDLE
module apuf_eval_ctrl #(
    parameter int line_length   = 64,
    parameter int repeats       = 15,
    parameter int settle_cycles = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [line_length-1:0]           req_challenge,
    output logic [line_length-1:0]           challenge_out,
    output logic                             launch,
    input  logic                             arb_in,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic                             resp_bit,
    output logic [$clog2(repeats+1)-1:0]     resp_ones,
    output logic                             busy
);

    // An even vote count could tie, and fewer than 3 settle cycles would
    // not cover the arb_in synchronizer latency.
    if (repeats < 1 || (repeats % 2) == 0) begin : g_bad_repeats
        $error("apuf_eval_ctrl: repeats must be odd and >= 1");
    end
    if (settle_cycles < 3) begin : g_bad_settle
        $error("apuf_eval_ctrl: settle_cycles must be >= 3");
    end

    localparam int CW = $clog2(repeats + 1);
    localparam int PW = $clog2(settle_cycles + 1);

    localparam logic [CW-1:0] REP_LAST   = CW'(repeats - 1);
    localparam logic [CW-1:0] HALF       = CW'(repeats / 2);
    localparam logic [PW-1:0] PHASE_LAST = PW'(settle_cycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [1:0]      arb_sync;
    logic            arb_s;
    logic [PW-1:0]   ph_cnt;
    logic [CW-1:0]   rep_cnt;
    logic [CW-1:0]   ones_cnt;

    logic            phase_last;
    logic            rep_last;
    logic            accept;
    logic            resp_done;
    logic            capture;
    logic            req_ready_nxt;
    logic            launch_nxt;
    logic            resp_valid_nxt;

    assign arb_s      = arb_sync[1];
    assign phase_last = (ph_cnt == PHASE_LAST);
    assign rep_last   = (rep_cnt == REP_LAST);
    assign accept     = (state == ST_IDLE) && req_valid && req_ready;
    assign resp_done  = resp_valid && resp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (accept)     state_nxt = ST_PRECHARGE;
            ST_PRECHARGE: if (phase_last) state_nxt = ST_LAUNCH;
            ST_LAUNCH:    if (phase_last) state_nxt = ST_SAMPLE;
            ST_SAMPLE:    state_nxt = rep_last ? ST_RESP : ST_PRECHARGE;
            ST_RESP:      if (resp_done)  state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, so every
    // output pin (launch in particular) comes straight from a flop.
    always_comb begin
        busy           = (state != ST_IDLE);
        req_ready_nxt  = (state_nxt == ST_IDLE);
        launch_nxt     = (state_nxt == ST_LAUNCH) || (state_nxt == ST_SAMPLE);
        // First RESP cycle captures the final count; resp_valid follows a cycle later.
        capture        = (state == ST_RESP) && !resp_valid;
        resp_valid_nxt = (state == ST_RESP) && !resp_done;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arb_sync      <= '0;
            req_ready     <= 1'b0;
            launch        <= 1'b0;
            resp_valid    <= 1'b0;
            resp_bit      <= 1'b0;
            resp_ones     <= '0;
            challenge_out <= '0;
            ph_cnt        <= '0;
            rep_cnt       <= '0;
            ones_cnt      <= '0;
        end else begin
            arb_sync   <= {arb_sync[0], arb_in};
            req_ready  <= req_ready_nxt;
            launch     <= launch_nxt;
            resp_valid <= resp_valid_nxt;

            // Challenge only moves on accept, so the line is never
            // reconfigured while an edge is in flight.
            if (accept) begin
                challenge_out <= req_challenge;
                ones_cnt      <= '0;
                rep_cnt       <= '0;
            end

            if (state != state_nxt) begin
                ph_cnt <= '0;
            end else if (state == ST_PRECHARGE || state == ST_LAUNCH) begin
                ph_cnt <= ph_cnt + PW'(1);
            end

            if (state == ST_SAMPLE) begin
                ones_cnt <= ones_cnt + CW'(arb_s);
                rep_cnt  <= rep_cnt + CW'(1);
            end

            if (capture) begin
                resp_ones <= ones_cnt;
                resp_bit  <= (ones_cnt > HALF);
            end
        end
    end

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
module tb_apuf_eval_ctrl;

    localparam int LL  = 8;
    localparam int RA  = 5;
    localparam int SA  = 4;
    localparam int RB  = 1;
    localparam int SB  = 3;
    localparam int OWA = $clog2(RA + 1);
    localparam int OWB = $clog2(RB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;

    logic            req_valid_a, req_ready_a, launch_a, arb_in_a;
    logic            resp_valid_a, resp_ready_a, resp_bit_a, busy_a;
    logic [LL-1:0]   req_challenge_a, challenge_out_a;
    logic [OWA-1:0]  resp_ones_a;

    logic            req_valid_b, req_ready_b, launch_b, arb_in_b;
    logic            resp_valid_b, resp_ready_b, resp_bit_b, busy_b;
    logic [LL-1:0]   req_challenge_b, challenge_out_b;
    logic [OWB-1:0]  resp_ones_b;

    apuf_eval_ctrl #(.line_length(LL), .repeats(RA), .settle_cycles(SA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_challenge(req_challenge_a),
        .challenge_out(challenge_out_a), .launch(launch_a), .arb_in(arb_in_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a), .resp_bit(resp_bit_a),
        .resp_ones(resp_ones_a), .busy(busy_a)
    );

    apuf_eval_ctrl #(.line_length(LL), .repeats(RB), .settle_cycles(SB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_challenge(req_challenge_b),
        .challenge_out(challenge_out_b), .launch(launch_b), .arb_in(arb_in_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_bit(resp_bit_b),
        .resp_ones(resp_ones_b), .busy(busy_b)
    );

    typedef struct {
        logic [LL-1:0]  chal;
        logic [RA-1:0]  pat;    // pat[k] = arb_in during evaluation k
        int             bp;     // cycles resp_ready held low after resp_valid
        logic [OWA-1:0] ones;
        logic           rbit;
    } vec_t;

    typedef struct {
        logic [OWA-1:0] ones;
        logic           rbit;
        logic [LL-1:0]  chal;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    vec_t after_rst;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic run_a(input vec_t v);
        int   w;
        int   lat;
        exp_t e;
        resp_ready_a = (v.bp == 0);
        w = 0;
        while (!req_ready_a && w < 10) begin
            tick();
            w++;
        end
        chk("a_req_ready_idle", req_ready_a, 1);
        req_valid_a     = 1'b1;
        req_challenge_a = v.chal;
        tick();                                   // accept edge
        req_valid_a     = 1'b0;
        req_challenge_a = ~v.chal;                // must not be resampled
        sb_q.push_back('{ones: v.ones, rbit: v.rbit, chal: v.chal});
        chk("a_challenge_after_accept", challenge_out_a, v.chal);
        chk("a_req_ready_busy", req_ready_a, 0);
        chk("a_busy", busy_a, 1);
        for (int k = 0; k < RA; k++) begin
            arb_in_a = v.pat[k];
            for (int j = 0; j < 2 * SA + 1; j++) begin
                chk("a_launch_pattern", launch_a, (j >= SA));
                tick();
            end
            chk("a_challenge_held", challenge_out_a, v.chal);
        end
        chk("a_resp_valid_early", resp_valid_a, 0);
        lat = RA * (2 * SA + 1);
        while (!resp_valid_a && lat < 80) begin
            tick();
            lat++;
        end
        chk("a_resp_latency", lat, 46);
        chk("a_launch_resp", launch_a, 0);
        for (int i = 0; i < v.bp; i++) begin
            req_valid_a     = (i == 3);
            req_challenge_a = 8'h3C;
            tick();
            chk("a_bp_resp_valid", resp_valid_a, 1);
            chk("a_bp_resp_ones", resp_ones_a, v.ones);
            chk("a_bp_resp_bit", resp_bit_a, v.rbit);
            chk("a_bp_req_ready", req_ready_a, 0);
            chk("a_bp_challenge", challenge_out_a, v.chal);
        end
        req_valid_a  = 1'b0;
        resp_ready_a = 1'b1;
        // scoreboard: response is presented and accepted at the next edge
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_scoreboard: response with empty queue");
        end else begin
            e = sb_q.pop_front();
            chk("a_resp_ones", resp_ones_a, e.ones);
            chk("a_resp_bit", resp_bit_a, e.rbit);
            chk("a_resp_challenge", challenge_out_a, e.chal);
        end
        tick();
        chk("a_resp_valid_dropped", resp_valid_a, 0);
        chk("a_req_ready_return", req_ready_a, 1);
        chk("a_busy_done", busy_a, 0);
        chk("a_challenge_kept", challenge_out_a, v.chal);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   w;
        int   lat;
        exp_t e;

        vecs[0] = '{chal: 8'hA5, pat: 5'b11111, bp: 0,  ones: 3'd5, rbit: 1'b1};
        vecs[1] = '{chal: 8'h5A, pat: 5'b10101, bp: 0,  ones: 3'd3, rbit: 1'b1};
        vecs[2] = '{chal: 8'hC3, pat: 5'b01001, bp: 0,  ones: 3'd2, rbit: 1'b0};
        vecs[3] = '{chal: 8'hA5, pat: 5'b11010, bp: 10, ones: 3'd3, rbit: 1'b1};
        vecs[4] = '{chal: 8'hFF, pat: 5'b00000, bp: 0,  ones: 3'd0, rbit: 1'b0};
        after_rst = '{chal: 8'h69, pat: 5'b11111, bp: 0, ones: 3'd5, rbit: 1'b1};

        rst_n = 1'b0;
        req_valid_a = 1'b0; req_challenge_a = '0; arb_in_a = 1'b0; resp_ready_a = 1'b1;
        req_valid_b = 1'b0; req_challenge_b = '0; arb_in_b = 1'b0; resp_ready_b = 1'b1;

        // Reset state
        tick(); tick(); tick();
        chk("rst_req_ready", req_ready_a, 0);
        chk("rst_launch", launch_a, 0);
        chk("rst_challenge", challenge_out_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_resp_valid", resp_valid_a, 0);
        chk("rst_resp_ones", resp_ones_a, 0);
        chk("rst_resp_bit", resp_bit_a, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", req_ready_a, 1);
        chk("idle_launch", launch_a, 0);
        chk("idle_challenge", challenge_out_a, 0);
        chk("idle_busy", busy_a, 0);

        for (int i = 0; i < 5; i++) begin
            run_a(vecs[i]);
        end

        // Reset in the middle of the third LAUNCH phase
        req_valid_a     = 1'b1;
        req_challenge_a = 8'h96;
        arb_in_a        = 1'b1;
        tick();
        req_valid_a = 1'b0;
        for (int i = 0; i < 2 * (2 * SA + 1) + SA; i++) tick();
        chk("mid_launch_high", launch_a, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_launch", launch_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_challenge", challenge_out_a, 0);
        chk("mid_rst_req_ready", req_ready_a, 0);
        chk("mid_rst_resp_valid", resp_valid_a, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_req_ready_back", req_ready_a, 1);
        run_a(after_rst);

        // repeats=1, settle_cycles=3, arb_in=0
        w = 0;
        while (!req_ready_b && w < 10) begin
            tick();
            w++;
        end
        chk("b_req_ready_idle", req_ready_b, 1);
        req_valid_b     = 1'b1;
        req_challenge_b = 8'h81;
        tick();
        req_valid_b = 1'b0;
        sb_q.push_back('{ones: 3'd0, rbit: 1'b0, chal: 8'h81});
        lat = 0;
        while (!resp_valid_b && lat < 40) begin
            chk("b_launch_pattern", launch_b, (lat >= SB && lat <= 2 * SB));
            tick();
            lat++;
        end
        chk("b_resp_latency", lat, 8);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_scoreboard: response with empty queue");
        end else begin
            e = sb_q.pop_front();
            chk("b_resp_ones", resp_ones_b, e.ones);
            chk("b_resp_bit", resp_bit_b, e.rbit);
            chk("b_resp_challenge", challenge_out_b, e.chal);
        end
        tick();
        chk("b_resp_valid_dropped", resp_valid_b, 0);
        chk("b_req_ready_return", req_ready_b, 1);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
